// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into little-endian words and writes them
// to consecutive instruction-memory addresses, keeping a running checksum.
module imem_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_add,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] add_1,
    output logic [31:0]       data_1,
    output logic              we_1,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, add_q, add_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d, dat_q, dat_d, sum_q, sum_d;

    assign byte_ready = state_q == RECV && !abort;
    assign we_1       = state_q == WRITE && !abort;
    assign done       = state_q == DONE && !abort;
    assign busy       = state_q != IDLE;
    assign checksum   = sum_q;
    // The write port shows the live word only in WRITE and otherwise holds the last written one.
    assign add_1      = state_q == WRITE ? addr_q : add_q;
    assign data_1     = state_q == WRITE ? word_q : dat_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        add_d   = add_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        word_d  = word_q;
        dat_d   = dat_q;
        sum_d   = sum_q;
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    addr_d  = base_add;
                    rem_d   = word_count;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = word_count == '0 ? DONE : RECV;
                end
                RECV: if (byte_valid) begin
                    word_d[8*idx_q +: 8] = byte_data;
                    idx_d   = idx_q + 2'd1;
                    state_d = idx_q == 2'd3 ? WRITE : RECV;
                end
                WRITE: begin
                    sum_d   = sum_q + word_q;
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    idx_d   = '0;
                    add_d   = addr_q;
                    dat_d   = word_q;
                    state_d = rem_q == 'd1 ? DONE : RECV;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            add_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            dat_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            add_q   <= add_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            dat_q   <= dat_d;
            sum_q   <= sum_d;
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory through its write port. It accepts a byte stream (for example from a UART receiver) with a valid/ready handshake and packs each group of four bytes into a little-endian 32-bit word. Each word is written to consecutive word addresses starting at a given base address. It drives the memory's `add_1`/`data_1`/`we_1` port while the core is held off, and reports completion and a running checksum.

## Interface
- `ADDR_W`, default 12: word-address width of the instruction memory.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that begins a load. Ignored unless in IDLE.
- `abort`  in  1: cancels a load in progress. Has priority over everything except reset.
- `base_add`  in  ADDR_W: first word address. Sampled on an accepted `start`.
- `word_count`  in  ADDR_W+1: number of words to load, 0..2^ADDR_W. Sampled on an accepted `start`.
- `byte_valid`  in  1: byte source has data.
- `byte_data`  in  8: byte value.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `add_1`  out  ADDR_W: memory write address.
- `data_1`  out  32: memory write data.
- `we_1`  out  1: memory write enable, one cycle per word.
- `busy`  out  1: high in every state other than IDLE.
- `done`  out  1: one-cycle pulse when a load completes without abort.
- `checksum`  out  32: sum of all words written since the last accepted `start`, modulo 2^32.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE, on `start`=1:
  - capture `base_add` into the address register and `word_count` into the remaining-word register;
  - clear `checksum` and the byte index.
  - Go to DONE if `word_count`=0, otherwise go to RECV.
- RECV:
  - `byte_ready`=1.
  - A byte is accepted when `byte_valid`&&`byte_ready`.
  - Byte index k (0..3) goes to `data_1[8k+7:8k]`, so the first byte is the LSB.
  - Gaps in `byte_valid` stall the state with no other effect.
  - The 4th accepted byte moves the state to WRITE.
- WRITE:
  - `we_1`=1 for exactly one cycle, with `add_1`=current address and `data_1`=assembled word.
  - Same edge:
    - `checksum` += word;
    - address += 1, wrapping modulo 2^ADDR_W so that 0xFFF goes to 0x000;
    - remaining -= 1;
    - byte index clears.
  - Next state is DONE if remaining is now 0, otherwise RECV.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort`=1 in any state:
  - next state is IDLE;
  - `we_1` is forced to 0 that cycle, so no write occurs even in WRITE;
  - no `done`;
  - `byte_ready` is forced to 0 that cycle, so no byte is consumed;
  - a partial word is discarded;
  - `checksum` holds its value.
- `start` while `busy` is ignored, with no effect on any register.
- `add_1` and `data_1` hold their last values outside WRITE. Only `we_1` qualifies them.

## Timing
- Reset values:
  - state is IDLE;
  - `byte_ready`, `we_1`, `busy`, `done` are 0;
  - `add_1`, `data_1`, `checksum` are 0;
  - byte index and remaining are 0.
- Reset asserted mid-load returns to IDLE immediately and performs no further write.
- `byte_ready`, `we_1`, `busy`, `done` are decoded from the registered state and do not depend combinationally on `byte_valid`, with one exception: the `abort` gating described above.
- `busy` rises in the cycle after an accepted `start`.
- Word latency is 5 cycles minimum: 4 RECV byte cycles with `byte_valid` held high, then 1 WRITE cycle.
- N-word load with continuous bytes: `done` is asserted 1 + 5N cycles after the `start` cycle.
- `word_count`=0: `done` is asserted 1 cycle after `start`, with no writes.
- `word_count`=2^ADDR_W is legal. It writes the whole memory once, and the address wraps back to `base_add`.
- `checksum` is valid from the cycle after the last WRITE and holds until the next accepted `start`.

## Test plan
- Basic load:
  - stimulus: `base_add`=0x010, `word_count`=2, bytes 78 56 34 12 EF BE AD DE;
  - required: writes 0x12345678@0x010 then 0xDEADBEEF@0x011, `done` after 11 cycles, `checksum`=0xF0E21567.
- Wrap:
  - stimulus: `base_add`=0xFFF, `word_count`=2;
  - required: writes land at 0xFFF then 0x000.
- Stalls:
  - stimulus: same as the basic load, with `byte_valid` low for 3 cycles between every byte;
  - required: identical writes and checksum, `done` delayed by exactly the stall cycles, no extra `we_1`.
- Zero count:
  - stimulus: `word_count`=0;
  - required: `done` 1 cycle after `start`, `we_1` never high, `checksum`=0.
- Abort and restart:
  - stimulus: `abort` after 2 bytes of word 0, then a new `start` at 0x020 with `word_count`=1;
  - required: no write from the aborted load, no `done` for it;
  - the new word is assembled from fresh bytes only and written at 0x020.
- `start` while busy and reset mid-load:
  - stimulus: a second `start` pulse during RECV; later, `rstn` low during RECV;
  - required: the second `start` changes nothing;
  - after reset all outputs are 0 and no `we_1` follows.
